// File: rtl/mvu_jobctl.sv
// MVU job controller: descriptor FIFO feeding a launch/complete FSM that drives MVU config.
// Optional watchdog enabled by defining MVU_JOBCTL_TIMEOUT_EN (limit set by TMO).
module mvu_jobctl #(
   parameter int DEPTH = 4,
   parameter int BTAG  = 4,
   parameter int TMO   = 4096
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            job_valid,
   output logic            job_ready,
   input  logic [BTAG+85:0] job_desc,
   output logic            start,
   input  logic            irq,
   output logic [28:0]     countdown,
   output logic [5:0]      wprecision,
   output logic [5:0]      iprecision,
   output logic [5:0]      oprecision,
   output logic [8:0]      wbaseaddr,
   output logic [14:0]     ibaseaddr,
   output logic [14:0]     obaseaddr,
   output logic            cmpl_valid,
   input  logic            cmpl_ready,
   output logic [BTAG-1:0] cmpl_tag,
   output logic            cmpl_err,
   output logic            busy
);

   localparam int BJOB = BTAG + 86;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_BUSY, S_CMPL} state_e;

   state_e          state_q, state_d;
   logic [BJOB-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [85:0]     cfg_q, cfg_d;
   logic [BTAG-1:0] tag_q, tag_d;
   logic            full, empty, push, pop, tmo_hit;

   // ---------------- job FIFO ----------------
   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign job_ready = !full;
   assign push      = job_valid && !full;

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= job_desc;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_comb begin
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // ---------------- config / tag registers ----------------
   always_comb begin
      cfg_d = cfg_q;
      tag_d = tag_q;
      if (pop) begin
         cfg_d = mem_q[rptr_q][85:0];
         tag_d = mem_q[rptr_q][BJOB-1:86];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q <= '0;
         tag_q <= '0;
      end else begin
         cfg_q <= cfg_d;
         tag_q <= tag_d;
      end
   end

   assign {countdown, wprecision, iprecision, oprecision,
           wbaseaddr, ibaseaddr, obaseaddr} = cfg_q;
   assign cmpl_tag = tag_q;

   // ---------------- watchdog ----------------
`ifdef MVU_JOBCTL_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_q;
   logic          err_q;

   // counter sits at 0 outside BUSY, so it restarts on every BUSY entry
   assign tmo_hit = (state_q == S_BUSY) && (tmo_q == TW'(TMO - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == S_BUSY) ? tmo_q + TW'(1) : '0;
         if (state_q == S_BUSY && state_d == S_CMPL) err_q <= !irq;
      end
   end

   assign cmpl_err = err_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^TMO;   // limit only matters when the watchdog is compiled in
   assign tmo_hit    = 1'b0;
   assign cmpl_err   = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!empty) state_d = S_LOAD;
         S_LOAD:  state_d = S_START;
         S_START: state_d = S_BUSY;
         S_BUSY:  if (irq || tmo_hit) state_d = S_CMPL;
         S_CMPL:  if (cmpl_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop        = (state_q == S_IDLE) && !empty;
      start      = (state_q == S_START);
      cmpl_valid = (state_q == S_CMPL);
      busy       = (state_q != S_IDLE) || !empty;
   end

endmodule

// File: tb/tb_mvu_jobctl.sv
// Scoreboard bench for mvu_jobctl: stimulus queues expected config/completions,
// a negedge monitor checks them whenever start fires or a completion handshakes.
module tb_mvu_jobctl;
   localparam int DEPTH = 4;
   localparam int BTAG  = 4;
   localparam int TMO   = 64;
   localparam int BJOB  = BTAG + 86;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            job_valid = 1'b0, job_ready;
   logic [BJOB-1:0] job_desc = '0;
   logic            start, irq = 1'b0;
   logic [28:0]     countdown;
   logic [5:0]      wprecision, iprecision, oprecision;
   logic [8:0]      wbaseaddr;
   logic [14:0]     ibaseaddr, obaseaddr;
   logic            cmpl_valid, cmpl_ready = 1'b1, cmpl_err, busy;
   logic [BTAG-1:0] cmpl_tag;
   logic [85:0]     cfg_o;

   int vectors = 0, miscompares = 0, cyc = 0;
   logic [85:0]   exp_start_q[$];
   logic [BTAG:0] exp_cmpl_q[$];

   mvu_jobctl #(.DEPTH(DEPTH), .BTAG(BTAG), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
      .job_desc(job_desc), .start(start), .irq(irq), .countdown(countdown),
      .wprecision(wprecision), .iprecision(iprecision), .oprecision(oprecision),
      .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr), .obaseaddr(obaseaddr),
      .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_tag(cmpl_tag),
      .cmpl_err(cmpl_err), .busy(busy));

   assign cfg_o = {countdown, wprecision, iprecision, oprecision, wbaseaddr, ibaseaddr, obaseaddr};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: any start or completion handshake must match the head of its queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (start) begin
            if (exp_start_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL start_unexpected: got start cfg %0h expected none", cfg_o);
            end else chk("start_cfg", cfg_o, exp_start_q.pop_front());
         end
         if (cmpl_valid && cmpl_ready) begin
            if (exp_cmpl_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL cmpl_unexpected: got tag %0h err %0b expected none", cmpl_tag, cmpl_err);
            end else chk("cmpl_tag_err", {cmpl_tag, cmpl_err}, exp_cmpl_q.pop_front());
         end
      end
   end

   function automatic logic [BJOB-1:0] mk(input int tag, cd, wp, ip, op, wb, ib, ob);
      logic [BTAG-1:0] t;
      logic [28:0] c;
      logic [5:0]  w, i, o;
      logic [8:0]  wa;
      logic [14:0] ia, oa;
      t = BTAG'(tag); c = 29'(cd); w = 6'(wp); i = 6'(ip); o = 6'(op);
      wa = 9'(wb); ia = 15'(ib); oa = 15'(ob);
      return {t, c, w, i, o, wa, ia, oa};
   endfunction

   task automatic push(input logic [BJOB-1:0] d, input logic err, output int c);
      int n = 0;
      job_valid = 1'b1;
      job_desc  = d;
      @(negedge clk);
      while (!job_ready && n < 100) begin n++; @(negedge clk); end
      chk("push_accept", job_ready, 1);
      c = cyc;
      exp_start_q.push_back(d[85:0]);
      exp_cmpl_q.push_back({d[BJOB-1:86], err});
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_start(output int c);
      int n = 0;
      @(negedge clk);
      while (!start && n < 300) begin n++; @(negedge clk); end
      chk("start_seen", start, 1);
      c = cyc;
      @(posedge clk); #1;
   endtask

   task automatic wait_cmpl(output int c);
      int n = 0;
      @(negedge clk);
      while (!cmpl_valid && n < 300) begin n++; @(negedge clk); end
      chk("cmpl_seen", cmpl_valid, 1);
      c = cyc;
      @(posedge clk); #1;
   endtask

   task automatic irq_at(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
      irq = 1'b1;
      @(posedge clk); #1;
      irq = 1'b0;
   endtask

   initial begin
      int c0, c1, s, c, h;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_cmpl_valid", cmpl_valid, 0);
      chk("rst_cmpl_err", cmpl_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg", cfg_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_job_ready", job_ready, 1);
      @(posedge clk); #1;

      // single job: tag 3, countdown 16, precisions 2/2/2
      push(mk(3, 16, 2, 2, 2, 'h10, 'h100, 'h200), 1'b0, c0);
      wait_start(s);
      chk("lat_push_start", s - c0, 3);
      irq_at(s + 20);
      wait_cmpl(c);
      chk("lat_irq_cmpl", c, s + 21);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;

      // fill: 5 jobs, one launched, four queued
      for (int i = 0; i < 5; i++)
         push(mk(i, 100 + i, i + 1, i + 2, i + 3, i * 3, i * 5, i * 7), 1'b0, c1);
      @(negedge clk);
      chk("full_ready", job_ready, 0);
      chk("full_busy", busy, 1);
      @(posedge clk); #1;
      job_valid = 1'b1;
      job_desc  = mk(15, 1, 1, 1, 1, 1, 1, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_hold", job_ready, 0);
         @(posedge clk); #1;
      end
      job_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) wait_start(s);
         if (i == 1) chk("ready_after_pop", job_ready, 1);
         irq_at(cyc);
         wait_cmpl(c);
      end

      // completion back-pressure, then handshake-to-start latency
      cmpl_ready = 1'b0;
      push(mk(5, 500, 8, 4, 16, 'h1ff, 'h7fff, 'h1234), 1'b0, c0);
      push(mk(6, 600, 1, 2, 3, 'h0aa, 'h0555, 'h2aaa), 1'b0, c1);
      wait_start(s);
      irq_at(s + 2);
      wait_cmpl(c);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_valid", cmpl_valid, 1);
         chk("hold_tag", cmpl_tag, 5);
         @(posedge clk); #1;
      end
      cmpl_ready = 1'b1;
      @(negedge clk);
      h = cyc;
      chk("hs_valid", cmpl_valid, 1);
      @(posedge clk); #1;
      wait_start(s);
      chk("lat_hs_start", s - h, 3);
      irq_at(cyc);
      wait_cmpl(c);

      // spurious irq in IDLE and in START
      repeat (2) @(posedge clk);
      #1 irq = 1'b1;
      repeat (3) @(posedge clk);
      #1 irq = 1'b0;
      @(negedge clk);
      chk("idle_irq_busy", busy, 0);
      chk("idle_irq_cmpl", cmpl_valid, 0);
      @(posedge clk); #1;
      push(mk(8, 80, 5, 6, 7, 8, 9, 10), 1'b0, c0);
      while (cyc < c0 + 3) begin @(posedge clk); #1; end
      irq = 1'b1;
      @(negedge clk);
      chk("start_with_irq", start, 1);
      @(posedge clk); #1;
      irq = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      chk("start_irq_no_cmpl", cmpl_valid, 0);
      chk("start_irq_busy", busy, 1);
      @(posedge clk); #1;
      irq_at(cyc);
      wait_cmpl(c);

      // reset mid-job with two queued
      push(mk(7, 70, 1, 1, 1, 1, 1, 1), 1'b0, c0);
      wait_start(s);
      push(mk(9, 90, 2, 2, 2, 2, 2, 2), 1'b0, c1);
      push(mk(10, 99, 3, 3, 3, 3, 3, 3), 1'b0, c1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_start_q.delete();
      exp_cmpl_q.delete();
      @(negedge clk);
      chk("mid_rst_start", start, 0);
      chk("mid_rst_cmpl_valid", cmpl_valid, 0);
      chk("mid_rst_cmpl_err", cmpl_err, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cfg", cfg_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", job_ready, 1);
      chk("mid_rel_busy", busy, 0);
      @(posedge clk); #1;
      irq_at(cyc + 3);
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cmpl", cmpl_valid, 0);
      @(posedge clk); #1;

`ifdef MVU_JOBCTL_TIMEOUT_EN
      // watchdog: no irq, completion with error TMO cycles after BUSY entry
      push(mk(11, 1000, 4, 4, 4, 4, 4, 4), 1'b1, c0);
      wait_start(s);
      wait_cmpl(c);
      chk("tmo_lat", c, s + 1 + TMO);
`endif

      chk("start_q_drained", exp_start_q.size(), 0);
      chk("cmpl_q_drained", exp_cmpl_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
